// File: rtl/decode_issue_stage.sv
// Multi-lane RV32I control decode with younger-lane squash and an illegal-opcode counter.
// Latency: 1 cycle from accept to out_valid_o; full throughput while out_ready_i is high.
// Backpressure: holds the registered group while out_valid_o & ~out_ready_i; flush_i drops it.
module decode_issue_stage #(
    parameter int LANES     = 2,
    parameter int ILL_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid_i,
    input  logic [LANES-1:0]       in_lane_valid_i,
    input  logic [7*LANES-1:0]     op_i,
    output logic                   in_ready_o,
    input  logic                   flush_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [LANES-1:0]       out_lane_valid_o,
    output logic [11*LANES-1:0]    ctrl_o,
    output logic [LANES-1:0]       illegal_o,
    output logic [ILL_CNT_W-1:0]   ill_cnt_o
);

    typedef struct packed {
        logic       reg_write;
        logic [1:0] imm_src;
        logic       alu_src;
        logic       mem_write;
        logic [1:0] result_src;
        logic       branch;
        logic [1:0] alu_op;
        logic       jump;
    } ctrl_t;

    ctrl_t [LANES-1:0]     dec_ctrl;
    logic  [LANES-1:0]     dec_ill;
    logic  [LANES-1:0]     sq_valid;
    logic  [LANES-1:0]     sq_ill;
    logic                  kill;
    logic                  accept;
    logic                  any_ill;

    ctrl_t [LANES-1:0]     ctrl_q;
    logic                  out_valid_q;
    logic  [LANES-1:0]     lane_valid_q;
    logic  [LANES-1:0]     illegal_q;
    logic  [ILL_CNT_W-1:0] ill_cnt_q;

    always_comb begin
        dec_ctrl = '0;
        dec_ill  = '0;
        for (int i = 0; i < LANES; i++) begin
            case (op_i[7*i +: 7])
                7'b0000011: dec_ctrl[i] = 11'b1_00_1_0_01_0_00_0;
                7'b0100011: dec_ctrl[i] = 11'b0_01_1_1_00_0_00_0;
                7'b0110011: dec_ctrl[i] = 11'b1_00_0_0_00_0_10_0;
                7'b0010011: dec_ctrl[i] = 11'b1_00_1_0_00_0_10_0;
                7'b1100011: dec_ctrl[i] = 11'b0_10_0_0_00_1_01_0;
                7'b1101111: dec_ctrl[i] = 11'b1_11_0_0_10_0_00_1;
                7'b1100111: dec_ctrl[i] = 11'b1_00_1_0_10_0_00_1;
                7'b0110111: dec_ctrl[i] = 11'b1_11_1_0_00_0_11_0;
                7'b0010111: dec_ctrl[i] = 11'b1_00_1_0_00_0_01_0;
                7'b0000000: dec_ctrl[i] = '0;
                default:    dec_ill[i]  = 1'b1;
            endcase
        end
    end

    // The oldest surviving control transfer or illegal lane kills everything younger.
    always_comb begin
        kill     = 1'b0;
        sq_valid = '0;
        for (int i = 0; i < LANES; i++) begin
            sq_valid[i] = in_lane_valid_i[i] & ~kill;
            if (sq_valid[i] & (dec_ctrl[i].branch | dec_ctrl[i].jump | dec_ill[i]))
                kill = 1'b1;
        end
    end

    assign sq_ill     = dec_ill & sq_valid;
    assign any_ill    = |sq_ill;
    assign in_ready_o = rst_n & ~flush_i & (~out_valid_q | out_ready_i);
    assign accept     = in_valid_i & in_ready_o;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            lane_valid_q <= '0;
            ctrl_q       <= '0;
            illegal_q    <= '0;
            ill_cnt_q    <= '0;
        end else if (flush_i) begin
            // ctrl is left as-is; consumers gate on the cleared lane mask.
            out_valid_q  <= 1'b0;
            lane_valid_q <= '0;
            illegal_q    <= '0;
        end else if (accept) begin
            out_valid_q  <= 1'b1;
            lane_valid_q <= sq_valid;
            ctrl_q       <= dec_ctrl;
            illegal_q    <= sq_ill;
            if (any_ill && !(&ill_cnt_q))
                ill_cnt_q <= ill_cnt_q + ILL_CNT_W'(1);
        end else if (out_ready_i) begin
            out_valid_q  <= 1'b0;
        end
    end

    assign out_valid_o      = out_valid_q;
    assign out_lane_valid_o = lane_valid_q;
    assign ctrl_o           = ctrl_q;
    assign illegal_o        = illegal_q;
    assign ill_cnt_o        = ill_cnt_q;

endmodule

// File: doc/decode_issue_stage.md
# decode_issue_stage

Parametrised, registered control-decode stage for the superscalar front end. Decodes LANES RV32I opcodes per cycle into per-lane control words, then registers them behind a valid/ready handshake. Squashes lanes younger than a control transfer or illegal opcode, and keeps a saturating illegal-opcode counter. Sits between fetch/issue-group formation and the register-read stage. It replaces the bare combinational main decode with a pipelined, multi-lane block.

## Interface
- LANES, 2: decode lanes per issue group; lane 0 is oldest; legal range 1..4.
- ILL_CNT_W, 8: illegal-counter width.
- Reset is synchronous and active-low.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid_i  input  1  issue group presented.
- in_lane_valid_i  input  LANES  per-lane occupancy of the presented group.
- op_i  input  7*LANES  opcodes; lane i occupies [7i+6:7i].
- in_ready_o  output  1  stage accepts a group this cycle.
- flush_i  input  1  discards the held group and blocks acceptance.
- out_valid_o  output  1  registered group valid.
- out_ready_i  input  1  downstream consumes the group.
- out_lane_valid_o  output  LANES  post-squash lane mask.
- ctrl_o  output  11*LANES  lane i occupies [11i+10:11i], ordered {RegWrite, ImmSrc[1:0], ALUSrc, MemWrite, ResultSrc[1:0], Branch, ALUop[1:0], Jump}.
- illegal_o  output  LANES  lane holds an unrecognised opcode.
- ill_cnt_o  output  ILL_CNT_W  count of accepted groups containing at least one valid illegal lane; saturating.

## Operation
- Per-lane decode (11-bit word as ordered above):
  - 0000011 lw: 1_00_1_0_01_0_00_0
  - 0100011 sw: 0_01_1_1_00_0_00_0
  - 0110011 R: 1_00_0_0_00_0_10_0
  - 0010011 I-ALU: 1_00_1_0_00_0_10_0
  - 1100011 branch: 0_10_0_0_00_1_01_0
  - 1101111 jal: 1_11_0_0_10_0_00_1
  - 1100111 jalr: 1_00_1_0_10_0_00_1
  - 0110111 lui: 1_11_1_0_00_0_11_0
  - 0010111 auipc: 1_00_1_0_00_0_01_0
  - 0000000 nop/bubble: all zero, not illegal.
  - any other opcode: all zero, illegal=1.
- No X is ever driven on ctrl_o.
- Squash rule, lane order 0→LANES-1:
  - A valid lane with Branch, Jump or illegal keeps its own valid bit.
  - Every younger lane's out_lane_valid bit is cleared.
  - Squashed lanes still carry their decoded ctrl/illegal bits; consumers must gate on out_lane_valid_o.
- illegal_o bit = decoded illegal AND the lane's post-squash valid.
- Counter: +1 per accepted group with any valid illegal lane (after squash); holds at all-ones; cleared only by reset.

## Timing
- Reset (rst_n=0 at edge):
  - out_valid_o, out_lane_valid_o, ctrl_o, illegal_o, ill_cnt_o all 0.
  - in_ready_o is 0 while rst_n=0.
- Handshake:
  - in_ready_o = rst_n & ~flush_i & (~out_valid_o | out_ready_i).
  - Accept when in_valid_i & in_ready_o.
  - Group appears on outputs the next cycle: latency 1.
  - Full throughput: one group/cycle while out_ready_i=1.
- Output holds stable while out_valid_o & ~out_ready_i; input is ignored.
- Consume without accept: out_valid_o falls next cycle; ctrl_o holds its last value.
- Flush:
  - flush_i=1 clears out_valid_o and out_lane_valid_o next cycle, even if out_ready_i=0.
  - No group is accepted that cycle.
  - Counter is not incremented for the unaccepted group.
- in_valid_i=1 with in_lane_valid_i=0: group accepted, out_valid_o=1, mask 0, counter unchanged.
- Reset mid-stall discards the held group.

## Test plan
- Reset: rst_n=0 for 2 cycles with in_valid_i=1 -> all outputs 0, in_ready_o=0; after release, in_ready_o=1.
- LANES=2, ops {lane1 lw, lane0 R}, mask 11 -> next cycle ctrl_o = {1_00_1_0_01_0_00_0, 1_00_0_0_00_0_10_0}, out_lane_valid_o=11, illegal_o=00.
- Lane0 jal, lane1 sw, mask 11 -> out_lane_valid_o=01, lane0 Jump=1.
- Lane0 opcode 1111111, lane1 R -> illegal_o=01, out_lane_valid_o=01, ill_cnt_o 0→1.
- Back-pressure: out_ready_i=0 for 3 cycles with new groups offered -> outputs unchanged, in_ready_o=0; out_ready_i=1 -> next group taken, no loss or duplication.
- Flush with out_valid_o=1, out_ready_i=0 and in_valid_i=1 -> next cycle out_valid_o=0, no acceptance.
- Counter: ILL_CNT_W=2, 5 illegal groups -> ill_cnt_o reads 1,2,3,3,3.
